// File: rtl/w5300_pkg.sv
// Shared constants and types for the W5300 bring-up sequencer.
package w5300_pkg;

    localparam logic [9:0] ADDR_MR    = 10'h000;
    localparam logic [9:0] ADDR_SHAR0 = 10'h008;
    localparam logic [9:0] ADDR_SHAR1 = 10'h00A;
    localparam logic [9:0] ADDR_SHAR2 = 10'h00C;
    localparam logic [9:0] ADDR_GAR0  = 10'h010;
    localparam logic [9:0] ADDR_GAR1  = 10'h012;
    localparam logic [9:0] ADDR_SUBR0 = 10'h014;
    localparam logic [9:0] ADDR_SUBR1 = 10'h016;
    localparam logic [9:0] ADDR_SIPR0 = 10'h018;
    localparam logic [9:0] ADDR_SIPR1 = 10'h01A;
    localparam logic [9:0] ADDR_IDR   = 10'h3FE;

    localparam logic [15:0] IDR_VAL = 16'h5300;

    // if_uaddr fields: bit 11 is an active-low request valid, bit 10 selects write
    localparam int unsigned VALID_N    = 11;
    localparam int unsigned WR         = 10;
    localparam logic [11:0] UADDR_IDLE = 12'h800;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_IDR      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_READBACK = 2'd3;

    localparam logic [3:0] LAST_STEP = 4'd10;

    typedef enum logic [2:0] {
        S_WAIT_IF,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_CHECK,
        S_READY,
        S_FAIL
    } state_e;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [15:0] data;
        logic        check_en;
    } rom_entry_t;

endpackage

// File: rtl/w5300_init_rom.sv
// Configuration script: maps a step index to one register access.
module w5300_init_rom
    import w5300_pkg::*;
#(
    parameter logic [15:0] MR_VAL   = 16'hB800,
    parameter logic [47:0] MAC      = 48'h00_08_DC_01_02_03,
    parameter logic [31:0] GW_IP    = 32'hC0A8_0001,
    parameter logic [31:0] SUBNET   = 32'hFFFF_FF00,
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_000A
) (
    input  logic [3:0] step,
    output rom_entry_t entry
);

    always_comb begin
        entry = '{wr: 1'b0, addr: ADDR_IDR, data: IDR_VAL, check_en: 1'b1};
        case (step)
            4'd0:    entry = '{wr: 1'b0, addr: ADDR_IDR,   data: IDR_VAL,         check_en: 1'b1};
            4'd1:    entry = '{wr: 1'b1, addr: ADDR_MR,    data: MR_VAL,          check_en: 1'b0};
            4'd2:    entry = '{wr: 1'b1, addr: ADDR_SHAR0, data: MAC[47:32],      check_en: 1'b0};
            4'd3:    entry = '{wr: 1'b1, addr: ADDR_SHAR1, data: MAC[31:16],      check_en: 1'b0};
            4'd4:    entry = '{wr: 1'b1, addr: ADDR_SHAR2, data: MAC[15:0],       check_en: 1'b0};
            4'd5:    entry = '{wr: 1'b1, addr: ADDR_GAR0,  data: GW_IP[31:16],    check_en: 1'b0};
            4'd6:    entry = '{wr: 1'b1, addr: ADDR_GAR1,  data: GW_IP[15:0],     check_en: 1'b0};
            4'd7:    entry = '{wr: 1'b1, addr: ADDR_SUBR0, data: SUBNET[31:16],   check_en: 1'b0};
            4'd8:    entry = '{wr: 1'b1, addr: ADDR_SUBR1, data: SUBNET[15:0],    check_en: 1'b0};
            4'd9:    entry = '{wr: 1'b1, addr: ADDR_SIPR0, data: LOCAL_IP[31:16], check_en: 1'b0};
            4'd10:   entry = '{wr: 1'b1, addr: ADDR_SIPR1, data: LOCAL_IP[15:0],  check_en: 1'b0};
            default: entry = '{wr: 1'b0, addr: ADDR_IDR,   data: IDR_VAL,         check_en: 1'b1};
        endcase
    end

endmodule

// File: rtl/w5300_init_seq.sv
// W5300 bring-up sequencer: checks IDR, writes network config, then passes user accesses through.
// Define W5300_SEQ_READBACK_EN to verify every script write with a read of the same address.
module w5300_init_seq
    import w5300_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100,
    parameter int unsigned TIMEOUT_US = 10,
    parameter logic [15:0] MR_VAL     = 16'hB800,
    parameter logic [47:0] MAC        = 48'h00_08_DC_01_02_03,
    parameter logic [31:0] GW_IP      = 32'hC0A8_0001,
    parameter logic [31:0] SUBNET     = 32'hFFFF_FF00,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_000A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        usr_req,
    input  logic        usr_wr,
    input  logic [9:0]  usr_addr,
    input  logic [15:0] usr_wdata,
    output logic        usr_ack,
    output logic [15:0] usr_rdata,
    output logic        init_done,
    output logic        init_err,
    output logic [1:0]  err_code,
    output logic [11:0] if_uaddr,
    output logic [15:0] if_wr_data,
    input  logic [15:0] if_rd_data,
    input  logic        if_op_status
);

    localparam int unsigned TO_CYCLES = CLK_FREQ * TIMEOUT_US;
    localparam logic [15:0] TO_LIMIT  = (TO_CYCLES > 32'd65535) ? 16'hFFFF : 16'(TO_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic        rb_q, rb_d;
    logic        usr_q, usr_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        req_wr_q, req_wr_d;
    logic [9:0]  req_addr_q, req_addr_d;
    logic [15:0] req_data_q, req_data_d;
    logic [15:0] rdata_q, rdata_d;
    logic [11:0] if_uaddr_q, if_uaddr_d;
    logic [15:0] if_wr_data_q, if_wr_data_d;
    logic        usr_ack_q, usr_ack_d;
    logic [15:0] usr_rdata_q, usr_rdata_d;
    logic        init_done_q, init_done_d;
    logic        init_err_q, init_err_d;
    logic [1:0]  err_code_q, err_code_d;

    rom_entry_t  rom;
    logic        cur_wr;
    logic [9:0]  cur_addr;
    logic [15:0] cur_data;
    logic        need_rb;
    logic        timed_out;
    logic [15:0] to_inc;

    w5300_init_rom #(
        .MR_VAL   (MR_VAL),
        .MAC      (MAC),
        .GW_IP    (GW_IP),
        .SUBNET   (SUBNET),
        .LOCAL_IP (LOCAL_IP)
    ) u_rom (
        .step  (step_q),
        .entry (rom)
    );

    // A readback pass reuses the current step's address as a read
    assign cur_wr   = usr_q ? req_wr_q   : (rom.wr & ~rb_q);
    assign cur_addr = usr_q ? req_addr_q : rom.addr;
    assign cur_data = usr_q ? req_data_q : rom.data;

`ifdef W5300_SEQ_READBACK_EN
    assign need_rb = rom.wr & ~rb_q;
`else
    assign need_rb = 1'b0;
`endif

    assign timed_out = (to_cnt_q >= TO_LIMIT);
    assign to_inc    = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        rb_d         = rb_q;
        usr_d        = usr_q;
        wait_cnt_d   = wait_cnt_q;
        to_cnt_d     = to_cnt_q;
        req_wr_d     = req_wr_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        rdata_d      = rdata_q;
        if_uaddr_d   = if_uaddr_q;
        if_wr_data_d = if_wr_data_q;
        usr_ack_d    = 1'b0;
        usr_rdata_d  = usr_rdata_q;
        init_done_d  = init_done_q;
        init_err_d   = init_err_q;
        err_code_d   = err_code_q;

        unique case (state_q)
            S_WAIT_IF: begin
                // op_status is only trusted once it has been stable for 16 cycles
                if (if_op_status) begin
                    if (wait_cnt_q == 4'd15) begin
                        wait_cnt_d = 4'd0;
                        step_d     = 4'd0;
                        rb_d       = 1'b0;
                        usr_d      = 1'b0;
                        state_d    = S_ISSUE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end

            S_ISSUE: begin
                if_uaddr_d[VALID_N] = 1'b0;
                if_uaddr_d[WR]      = cur_wr;
                if_uaddr_d[9:0]     = cur_addr;
                if_wr_data_d        = cur_data;
                to_cnt_d            = 16'd0;
                state_d             = S_WAIT_ACC;
            end

            S_WAIT_ACC: begin
                to_cnt_d = to_inc;
                if (!if_op_status) begin
                    state_d = S_WAIT_DONE;
                end else if (timed_out) begin
                    if_uaddr_d = UADDR_IDLE;
                    init_err_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FAIL;
                end
            end

            S_WAIT_DONE: begin
                to_cnt_d = to_inc;
                if (if_op_status) begin
                    if_uaddr_d[VALID_N] = 1'b1;
                    rdata_d             = if_rd_data;
                    state_d             = S_CHECK;
                end else if (timed_out) begin
                    if_uaddr_d = UADDR_IDLE;
                    init_err_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_FAIL;
                end
            end

            S_CHECK: begin
                if (usr_q) begin
                    usr_ack_d = 1'b1;
                    if (!req_wr_q) begin
                        usr_rdata_d = rdata_q;
                    end
                    usr_d   = 1'b0;
                    state_d = S_READY;
                end else if ((rom.check_en || rb_q) && (rdata_q != rom.data)) begin
                    if_uaddr_d = UADDR_IDLE;
                    init_err_d = 1'b1;
                    err_code_d = rb_q ? ERR_READBACK : ERR_IDR;
                    state_d    = S_FAIL;
                end else if (need_rb) begin
                    rb_d    = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    rb_d = 1'b0;
                    if (step_q == LAST_STEP) begin
                        init_done_d = 1'b1;
                        state_d     = S_READY;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_READY: begin
                // usr_ack_q marks the ack cycle, where a still-held usr_req is stale
                if (usr_req && !usr_ack_q) begin
                    req_wr_d   = usr_wr;
                    req_addr_d = {usr_addr[9:1], 1'b0};
                    req_data_d = usr_wdata;
                    usr_d      = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_FAIL: begin
                state_d = S_FAIL;
            end

            default: begin
                state_d = S_WAIT_IF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT_IF;
            step_q       <= 4'd0;
            rb_q         <= 1'b0;
            usr_q        <= 1'b0;
            wait_cnt_q   <= 4'd0;
            to_cnt_q     <= 16'd0;
            req_wr_q     <= 1'b0;
            req_addr_q   <= 10'd0;
            req_data_q   <= 16'd0;
            rdata_q      <= 16'd0;
            if_uaddr_q   <= UADDR_IDLE;
            if_wr_data_q <= 16'd0;
            usr_ack_q    <= 1'b0;
            usr_rdata_q  <= 16'd0;
            init_done_q  <= 1'b0;
            init_err_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            rb_q         <= rb_d;
            usr_q        <= usr_d;
            wait_cnt_q   <= wait_cnt_d;
            to_cnt_q     <= to_cnt_d;
            req_wr_q     <= req_wr_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            rdata_q      <= rdata_d;
            if_uaddr_q   <= if_uaddr_d;
            if_wr_data_q <= if_wr_data_d;
            usr_ack_q    <= usr_ack_d;
            usr_rdata_q  <= usr_rdata_d;
            init_done_q  <= init_done_d;
            init_err_q   <= init_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign if_uaddr   = if_uaddr_q;
    assign if_wr_data = if_wr_data_q;
    assign usr_ack    = usr_ack_q;
    assign usr_rdata  = usr_rdata_q;
    assign init_done  = init_done_q;
    assign init_err   = init_err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_w5300_init_seq.sv
// Directed bench for w5300_init_seq with a behavioural W5300 interface model.
module tb_w5300_init_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        usr_req;
    logic        usr_wr;
    logic [9:0]  usr_addr;
    logic [15:0] usr_wdata;
    logic        usr_ack;
    logic [15:0] usr_rdata;
    logic        init_done;
    logic        init_err;
    logic [1:0]  err_code;
    logic [11:0] if_uaddr;
    logic [15:0] if_wr_data;
    logic [15:0] if_rd_data;
    logic        if_op_status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    w5300_init_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .usr_req      (usr_req),
        .usr_wr       (usr_wr),
        .usr_addr     (usr_addr),
        .usr_wdata    (usr_wdata),
        .usr_ack      (usr_ack),
        .usr_rdata    (usr_rdata),
        .init_done    (init_done),
        .init_err     (init_err),
        .err_code     (err_code),
        .if_uaddr     (if_uaddr),
        .if_wr_data   (if_wr_data),
        .if_rd_data   (if_rd_data),
        .if_op_status (if_op_status)
    );

    // Interface model: accepts a valid request, holds op_status low 5 cycles, logs every request
    logic [15:0] mem [512];
    logic [11:0] log_uaddr [256];
    logic [15:0] log_wdata [256];
    int          req_cnt = 0;
    int          mst;
    int          busy_cnt;
    logic [9:0]  cur_addr_m;
    int          hang_idx     = -1;
    logic [15:0] idr_val      = 16'h5300;
    logic [9:0]  fixed_addr   = 10'h200;
    logic [15:0] fixed_val    = 16'hBEEF;
    logic [9:0]  corrupt_addr = 10'h3FF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_op_status <= 1'b1;
            if_rd_data   <= 16'h0;
            mst          <= 0;
            busy_cnt     <= 0;
            cur_addr_m   <= 10'h0;
        end else begin
            case (mst)
                0: if (!if_uaddr[11]) begin
                    if (req_cnt < 256) begin
                        log_uaddr[req_cnt] <= if_uaddr;
                        log_wdata[req_cnt] <= if_wr_data;
                    end
                    if (if_uaddr[10]) mem[if_uaddr[9:1]] <= if_wr_data;
                    cur_addr_m   <= if_uaddr[9:0];
                    if_op_status <= 1'b0;
                    busy_cnt     <= 5;
                    mst          <= (req_cnt == hang_idx) ? 3 : 1;
                    req_cnt      <= req_cnt + 1;
                end
                1: if (busy_cnt == 1) begin
                    if_op_status <= 1'b1;
                    if (cur_addr_m == 10'h3FE) if_rd_data <= idr_val;
                    else if (cur_addr_m == fixed_addr) if_rd_data <= fixed_val;
                    else if (cur_addr_m == corrupt_addr) if_rd_data <= ~mem[cur_addr_m[9:1]];
                    else if_rd_data <= mem[cur_addr_m[9:1]];
                    mst <= 2;
                end else begin
                    busy_cnt <= busy_cnt - 1;
                end
                2: if (if_uaddr[11]) mst <= 0;
                default: ;
            endcase
        end
    end

    logic [11:0] exp_uaddr [32];
    logic [15:0] exp_wdata [32];
    int          n_exp;

    task automatic build_expected();
        logic [9:0]  a [11] = '{10'h3FE, 10'h000, 10'h008, 10'h00A, 10'h00C, 10'h010,
                                10'h012, 10'h014, 10'h016, 10'h018, 10'h01A};
        logic [15:0] d [11] = '{16'h5300, 16'hB800, 16'h0008, 16'hDC01, 16'h0203, 16'hC0A8,
                                16'h0001, 16'hFFFF, 16'hFF00, 16'hC0A8, 16'h000A};
        n_exp = 0;
        for (int i = 0; i < 11; i++) begin
            exp_uaddr[n_exp] = {1'b0, (i != 0), a[i]};
            exp_wdata[n_exp] = d[i];
            n_exp++;
`ifdef W5300_SEQ_READBACK_EN
            if (i != 0) begin
                exp_uaddr[n_exp] = {2'b00, a[i]};
                exp_wdata[n_exp] = d[i];
                n_exp++;
            end
`endif
        end
    endtask

    task automatic apply_reset();
        usr_req = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (!init_done && !init_err && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!init_done && !init_err) begin
            n_fail++;
            $display("FAIL init_wait: no init_done/init_err after %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_ack(input int budget, output bit got);
        int n = 0;
        got = 1'b0;
        while (!usr_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        got = usr_ack;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL usr_ack_wait: usr_ack=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if_uaddr, if_wr_data, usr_ack, usr_rdata, init_done, init_err, err_code} !==
            {12'h800, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: uaddr=%h wd=%h ack=%b rd=%h done=%b err=%b code=%0d, required 800/0/0/0/0/0/0",
                     if_uaddr, if_wr_data, usr_ack, usr_rdata, init_done, init_err, err_code);
        end
        base  = req_cnt;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (if_uaddr !== 12'h800 || req_cnt != base) begin
            n_fail++;
            $display("FAIL wait_if_idle: uaddr=%h reqs=%0d, required 800 and 0", if_uaddr, req_cnt - base);
        end
    endtask

    task automatic test_nominal();
        int base;
        apply_reset();
        base = req_cnt;
        wait_init(2000);
        @(negedge clk);
        n_checks++;
        if (req_cnt - base != n_exp) begin
            n_fail++;
            $display("FAIL nominal_count: %0d requests, required %0d", req_cnt - base, n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            n_checks++;
            if (log_uaddr[base+i] !== exp_uaddr[i] ||
                (exp_uaddr[i][10] && log_wdata[base+i] !== exp_wdata[i])) begin
                n_fail++;
                $display("FAIL nominal_req%0d: uaddr=%h wd=%h, required uaddr=%h wd=%h", i,
                         log_uaddr[base+i], log_wdata[base+i], exp_uaddr[i], exp_wdata[i]);
            end
        end
        n_checks++;
        if (init_done !== 1'b1 || init_err !== 1'b0 || err_code !== 2'd0 || if_uaddr[11] !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_status: done=%b err=%b code=%0d valid_n=%b, required 1/0/0/1",
                     init_done, init_err, err_code, if_uaddr[11]);
        end
    endtask

    task automatic test_user_access();
        int base;
        bit got;
        base      = req_cnt;
        usr_wr    = 1'b0;
        usr_addr  = 10'h200;
        usr_wdata = 16'h0;
        usr_req   = 1'b1;
        wait_ack(100, got);
        usr_req = 1'b0;
        n_checks++;
        if (usr_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL user_read_data: usr_rdata=%h, required BEEF", usr_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (usr_ack !== 1'b0 || usr_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL user_ack_pulse: ack=%b rd=%h one cycle later, required 0 and BEEF", usr_ack, usr_rdata);
        end
        n_checks++;
        if (req_cnt - base != 1 || log_uaddr[base] !== 12'h200) begin
            n_fail++;
            $display("FAIL user_read_req: %0d reqs uaddr=%h, required 1 and 200", req_cnt - base, log_uaddr[base]);
        end
        // bit0 of the user address must be dropped
        base      = req_cnt;
        usr_wr    = 1'b1;
        usr_addr  = 10'h203;
        usr_wdata = 16'h00AA;
        usr_req   = 1'b1;
        wait_ack(100, got);
        usr_req = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (req_cnt - base != 1 || log_uaddr[base] !== 12'h602 || log_wdata[base] !== 16'h00AA) begin
            n_fail++;
            $display("FAIL user_write_req: %0d reqs uaddr=%h wd=%h, required 1, 602, 00AA",
                     req_cnt - base, log_uaddr[base], log_wdata[base]);
        end
    endtask

    task automatic test_holdoff();
        int base;
        bit got;
        apply_reset();
        base     = req_cnt;
        usr_wr   = 1'b0;
        usr_addr = 10'h200;
        usr_req  = 1'b1;
        wait_init(2000);
        n_checks++;
        if (req_cnt - base != n_exp) begin
            n_fail++;
            $display("FAIL holdoff_script: %0d reqs at init_done, required %0d", req_cnt - base, n_exp);
        end
        wait_ack(100, got);
        usr_req = 1'b0;
        n_checks++;
        if (req_cnt - base != n_exp + 1 || log_uaddr[base+n_exp] !== 12'h200 || usr_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL holdoff_user: %0d reqs uaddr=%h rd=%h, required %0d, 200, BEEF",
                     req_cnt - base, log_uaddr[base+n_exp], usr_rdata, n_exp + 1);
        end
    endtask

    task automatic test_idr_mismatch();
        int base;
        idr_val = 16'h1234;
        apply_reset();
        base = req_cnt;
        wait_init(2000);
        repeat (5) @(negedge clk);
        n_checks++;
        if (init_err !== 1'b1 || err_code !== 2'd1 || init_done !== 1'b0 || if_uaddr !== 12'h800) begin
            n_fail++;
            $display("FAIL idr_status: err=%b code=%0d done=%b uaddr=%h, required 1/1/0/800",
                     init_err, err_code, init_done, if_uaddr);
        end
        n_checks++;
        if (req_cnt - base != 1) begin
            n_fail++;
            $display("FAIL idr_no_writes: %0d requests, required 1", req_cnt - base);
        end
        idr_val = 16'h5300;
    endtask

    task automatic test_timeout();
        int base;
        int n;
        int acks;
        apply_reset();
        base     = req_cnt;
        hang_idx = base + 4;
        n = 0;
        while (req_cnt - base < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!init_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (init_err !== 1'b1 || err_code !== 2'd2 || n < 990 || n > 1010) begin
            n_fail++;
            $display("FAIL timeout: err=%b code=%0d after %0d cycles, required 1/2 after ~1000",
                     init_err, err_code, n);
        end
        base     = req_cnt;
        acks     = 0;
        usr_wr   = 1'b0;
        usr_addr = 10'h200;
        usr_req  = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (usr_ack) acks++;
        end
        usr_req = 1'b0;
        n_checks++;
        if (acks != 0 || req_cnt != base || if_uaddr !== 12'h800 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_terminal: acks=%0d reqs=%0d uaddr=%h done=%b, required 0/0/800/0",
                     acks, req_cnt - base, if_uaddr, init_done);
        end
        hang_idx = -1;
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        apply_reset();
        base = req_cnt;
        n = 0;
        while (req_cnt - base < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if_uaddr !== 12'h800 || if_wr_data !== 16'h0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: uaddr=%h wd=%h done=%b, required 800/0/0",
                     if_uaddr, if_wr_data, init_done);
        end
        repeat (3) @(negedge clk);
        base  = req_cnt;
        rst_n = 1'b1;
        wait_init(2000);
        @(negedge clk);
        n_checks++;
        if (log_uaddr[base] !== 12'h3FE || req_cnt - base != n_exp || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: first=%h reqs=%0d done=%b, required 3FE, %0d, 1",
                     log_uaddr[base], req_cnt - base, init_done, n_exp);
        end
    endtask

`ifdef W5300_SEQ_READBACK_EN
    task automatic test_readback_err();
        corrupt_addr = 10'h010;
        apply_reset();
        wait_init(3000);
        repeat (5) @(negedge clk);
        n_checks++;
        if (init_err !== 1'b1 || err_code !== 2'd3 || log_uaddr[req_cnt-1] !== 12'h010) begin
            n_fail++;
            $display("FAIL readback_err: err=%b code=%0d last=%h, required 1/3/010",
                     init_err, err_code, log_uaddr[req_cnt-1]);
        end
        corrupt_addr = 10'h3FF;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        usr_req   = 1'b0;
        usr_wr    = 1'b0;
        usr_addr  = 10'h0;
        usr_wdata = 16'h0;
        build_expected();
        test_reset();
        test_nominal();
        test_user_access();
        test_holdoff();
        test_idr_mismatch();
        test_timeout();
        test_reset_mid();
`ifdef W5300_SEQ_READBACK_EN
        test_readback_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
